// File: rtl/matrix_result_reader.sv
// matrix_result_reader: drains a 64-word result RAM into a 2-deep ready/valid stream.
// Define MATRIX_READER_ROW_MAJOR_EN for row-major read order (default is column-major).
module matrix_result_reader #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [10:0]       clock_count
);
  localparam int H = ADDR_W / 2;
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [ADDR_W:0] seq_q, seq_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] occ;
  logic [EW-1:0] m0_q, m0_d, m1_q, m1_d, wr;
  logic [ADDR_W-1:0] iaddr_q;
  logic infl_q, done_q, done_d, go, pop, push;
  logic [10:0] cc_q, cc_d;
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (start ? RUN : IDLE) : (pop && out_last ? IDLE : RUN);
  // A read may issue only if the word it returns is sure to find a free FIFO slot.
  always_comb begin
    busy = state_q == RUN;
    go = state_q == IDLE && start;
    occ = {1'b0, cnt_q} + {2'b0, infl_q};
    ram_re = busy && !seq_q[ADDR_W] && (occ < 3'd2 || (pop && occ == 3'd2));
    done_d = busy && pop && out_last;
  end
`ifdef MATRIX_READER_ROW_MAJOR_EN
  assign ram_addr = {seq_q[H-1:0], seq_q[ADDR_W-1:H]};
`else
  assign ram_addr = seq_q[ADDR_W-1:0];
`endif
  assign out_valid = cnt_q != 2'd0;
  assign out_data = m0_q[DATA_W-1:0];
  assign out_index = m0_q[EW-1:DATA_W];
  assign out_last = out_valid && &out_index;
  assign done = done_q;
  assign clock_count = cc_q;
  assign pop = out_valid && out_ready;
  assign push = infl_q;
  assign wr = {iaddr_q, ram_rdata};
  always_comb begin
    seq_d = go ? '0 : seq_q + {{ADDR_W{1'b0}}, ram_re};
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    m0_d = pop ? (cnt_q == 2'd2 ? m1_q : wr) : (push && cnt_q == 2'd0 ? wr : m0_q);
    m1_d = push && cnt_q == (pop ? 2'd2 : 2'd1) ? wr : m1_q;
    cc_d = go ? '0 : (busy && cc_q != 11'h7ff ? cc_q + 11'd1 : cc_q);
  end
  always_ff @(posedge clk)
    if (reset) begin
      seq_q <= '0;
      cnt_q <= '0;
      m0_q <= '0;
      m1_q <= '0;
      iaddr_q <= '0;
      infl_q <= 1'b0;
      done_q <= 1'b0;
      cc_q <= '0;
    end else begin
      seq_q <= seq_d;
      cnt_q <= cnt_d;
      m0_q <= m0_d;
      m1_q <= m1_d;
      iaddr_q <= ram_addr;
      infl_q <= ram_re;
      done_q <= done_d;
      cc_q <= cc_d;
    end
endmodule
